control_registro4: RTL and testbench



---
 rtl/reg4_pkg.sv | 28 ++
 rtl/ctl_nib_sel.sv | 24 ++
 rtl/control_registro4.sv | 125 ++++++++++++
 tb/tb_control_registro4.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg4_pkg.sv
// Shared encodings for the registro4 sequencer: registro4 mode/direction codes,
// controller states and a counter-width helper.
package reg4_pkg;

  typedef enum logic [1:0] {
    MODO_SHIFT = 2'b00,
    MODO_ROT   = 2'b01,
    MODO_LOAD  = 2'b10
  } modoT;

  // DIR_MSB shifts toward Q3 (S_OUT=Q3); DIR_LSB shifts toward Q0 (S_OUT=Q0).
  typedef enum logic {
    DIR_MSB = 1'b0,
    DIR_LSB = 1'b1
  } dirT;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FLUSH
  } ctlStateT;

  function automatic int unsigned cntWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctl_nib_sel.sv
// Nibble multiplexer: picks the nibble to load from the held word, walking
// from the top nibble down when MSB-first and from nibble 0 up otherwise.
module ctl_nib_sel
  import reg4_pkg::*;
#(
  parameter int unsigned NIB = 4
) (
  input  logic [4*NIB-1:0]          word,
  input  logic [cntWidth(NIB)-1:0]  nibCnt,
  input  logic                      msbFirst,
  output logic [3:0]                nib
);

  int unsigned idx;

  always_comb begin
    idx = msbFirst ? (NIB - 1 - 32'(nibCnt)) : 32'(nibCnt);
    nib = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx == i) nib = word[4*i +: 4];
    end
  end

endmodule

// File: rtl/control_registro4.sv
// Parallel-to-serial sequencer for the registro4 universal shift register:
// accepts a word by valid/ready, loads it nibble by nibble and shifts it out.
module control_registro4
  import reg4_pkg::*;
#(
  parameter int unsigned NIB = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [4*NIB-1:0] REQ_DATA,
  input  logic             REQ_MSB,
  input  logic             SER_STALL,
  output logic             SER_BIT,
  output logic             SER_VALID,
  output logic             DONE,
  output logic             SR_ENB,
  output logic             SR_DIR,
  output logic [1:0]       SR_MODO,
  output logic [3:0]       SR_D,
  output logic             SR_SIN,
  input  logic             SR_SOUT
);

  localparam int unsigned   W        = 4 * NIB;
  localparam int unsigned   CW       = cntWidth(NIB);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  ctlStateT      state;
  logic [W-1:0]  wordHeld;
  dirT           dirHeld;
  logic [CW-1:0] nibCnt;
  logic [1:0]    shCnt;
  logic          readyReg;
  logic          serValidReg;
  logic          doneReg;
  logic [3:0]    curNib;

  ctl_nib_sel #(.NIB(NIB)) uNibSel (
    .word     (wordHeld),
    .nibCnt   (nibCnt),
    .msbFirst (dirHeld == DIR_MSB),
    .nib      (curNib)
  );

  // readyReg is held low through reset and rises on the first edge after
  // release, so it can only be high while the state is IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      wordHeld    <= '0;
      dirHeld     <= DIR_MSB;
      nibCnt      <= '0;
      shCnt       <= '0;
      readyReg    <= 1'b0;
      serValidReg <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      readyReg    <= 1'b0;
      serValidReg <= 1'b0;
      doneReg     <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_VALID && readyReg) begin
            wordHeld <= REQ_DATA;
            dirHeld  <= REQ_MSB ? DIR_MSB : DIR_LSB;
            nibCnt   <= '0;
            state    <= LOAD;
          end else begin
            readyReg <= 1'b1;
          end
        end
        LOAD: begin
          if (!SER_STALL) begin
            shCnt <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!SER_STALL) begin
            serValidReg <= 1'b1;
            shCnt       <= shCnt + 2'd1;
            if (shCnt == 2'd3) begin
              if (nibCnt == LAST_NIB) begin
                doneReg <= 1'b1;
                state   <= FLUSH;
              end else begin
                nibCnt <= nibCnt + CW'(1);
                state  <= LOAD;
              end
            end
          end
        end
        FLUSH: begin
          readyReg <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    SR_ENB  = 1'b0;
    SR_MODO = MODO_SHIFT;
    SR_D    = '0;
    case (state)
      LOAD: begin
        SR_ENB  = !SER_STALL;
        SR_MODO = MODO_LOAD;
        SR_D    = curNib;
      end
      SHIFT: SR_ENB = !SER_STALL;
      default: ;
    endcase
  end

  assign SR_DIR    = dirHeld;
  assign SR_SIN    = 1'b0;
  assign SER_BIT   = SR_SOUT;
  assign SER_VALID = serValidReg;
  assign DONE      = doneReg;
  assign REQ_READY = readyReg;

endmodule

// File: tb/tb_control_registro4.sv
// Bench for control_registro4: NIB=4 and NIB=1 instances, each driving a
// behavioural registro4 whose S_OUT is registered every clock.
module tb_control_registro4;
  import reg4_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N;

  logic        reqValid, reqReady, reqMsb, serStall, serBit, serValid, done;
  logic        srEnb, srDir, srSin, srSout;
  logic [15:0] reqData;
  logic [1:0]  srModo;
  logic [3:0]  srD, q0;

  logic        reqValid1, reqReady1, reqMsb1, serStall1, serBit1, serValid1, done1;
  logic        srEnb1, srDir1, srSin1, srSout1;
  logic [3:0]  reqData1;
  logic [1:0]  srModo1;
  logic [3:0]  srD1, q1;

  control_registro4 #(.NIB(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(reqValid), .REQ_READY(reqReady),
    .REQ_DATA(reqData), .REQ_MSB(reqMsb), .SER_STALL(serStall),
    .SER_BIT(serBit), .SER_VALID(serValid), .DONE(done),
    .SR_ENB(srEnb), .SR_DIR(srDir), .SR_MODO(srModo), .SR_D(srD),
    .SR_SIN(srSin), .SR_SOUT(srSout)
  );

  control_registro4 #(.NIB(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(reqValid1), .REQ_READY(reqReady1),
    .REQ_DATA(reqData1), .REQ_MSB(reqMsb1), .SER_STALL(serStall1),
    .SER_BIT(serBit1), .SER_VALID(serValid1), .DONE(done1),
    .SR_ENB(srEnb1), .SR_DIR(srDir1), .SR_MODO(srModo1), .SR_D(srD1),
    .SR_SIN(srSin1), .SR_SOUT(srSout1)
  );

  // registro4 model: no reset, S_OUT samples the outgoing end every clock.
  always @(posedge CLK) begin
    srSout <= (srDir == DIR_LSB) ? q0[0] : q0[3];
    if (srEnb) begin
      case (srModo)
        MODO_LOAD:  q0 <= srD;
        MODO_SHIFT: q0 <= (srDir == DIR_LSB) ? {srSin, q0[3:1]} : {q0[2:0], srSin};
        MODO_ROT:   q0 <= (srDir == DIR_LSB) ? {q0[0], q0[3:1]} : {q0[2:0], q0[3]};
        default: ;
      endcase
    end
  end

  always @(posedge CLK) begin
    srSout1 <= (srDir1 == DIR_LSB) ? q1[0] : q1[3];
    if (srEnb1) begin
      case (srModo1)
        MODO_LOAD:  q1 <= srD1;
        MODO_SHIFT: q1 <= (srDir1 == DIR_LSB) ? {srSin1, q1[3:1]} : {q1[2:0], srSin1};
        MODO_ROT:   q1 <= (srDir1 == DIR_LSB) ? {q1[0], q1[3:1]} : {q1[2:0], q1[3]};
        default: ;
      endcase
    end
  end

  int vecCnt = 0;
  int errCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        msb;
    logic [15:0] data;
    int          stA, lnA, stB, lnB;
    logic [15:0] expBits;
    int          expDone;
  } vecT;

  vecT vecs[6];

  task automatic runVec(input vecT v, input int idx);
    int c, bitsSeen, doneCyc, dirBad, validAfterStall, enbBad;
    logic [15:0] bits;
    logic prevStall, stallNow, expDir;
    bitsSeen = 0; doneCyc = -1; dirBad = 0; validAfterStall = 0; enbBad = 0;
    bits = '0; prevStall = 1'b0;
    expDir = v.msb ? DIR_MSB : DIR_LSB;
    @(posedge CLK); #1;
    reqValid = 1'b1; reqData = v.data; reqMsb = v.msb; serStall = 1'b0;
    @(negedge CLK);
    check($sformatf("v%0d_ready_start", idx), 32'(reqReady), 32'd1);
    for (c = 1; c <= 60 && doneCyc < 0; c++) begin
      @(posedge CLK); #1;
      reqValid = 1'b0;
      stallNow = (c >= v.stA && c < v.stA + v.lnA) || (c >= v.stB && c < v.stB + v.lnB);
      serStall = stallNow;
      @(negedge CLK);
      if (serValid) begin
        bits = {bits[14:0], serBit};
        bitsSeen++;
      end
      if (srDir !== expDir) dirBad++;
      if (prevStall && serValid) validAfterStall++;
      if (stallNow && srEnb) enbBad++;
      if (done) doneCyc = c;
      prevStall = stallNow;
    end
    @(posedge CLK); #1;
    serStall = 1'b0;
    @(negedge CLK);
    check($sformatf("v%0d_bits", idx), 32'(bits), 32'(v.expBits));
    check($sformatf("v%0d_bitcount", idx), 32'(bitsSeen), 32'd16);
    check($sformatf("v%0d_done_cycle", idx), 32'(doneCyc), 32'(v.expDone));
    check($sformatf("v%0d_ready_after", idx), 32'(reqReady), 32'd1);
    check($sformatf("v%0d_dir_held", idx), 32'(dirBad), 32'd0);
    check($sformatf("v%0d_valid_after_stall", idx), 32'(validAfterStall), 32'd0);
    check($sformatf("v%0d_enb_in_stall", idx), 32'(enbBad), 32'd0);
  endtask

  initial begin
    int doneSeen, firstReady, d1, d2, doneCnt;
    logic [15:0] w1, w2;
    logic [3:0] b1;

    // msb, data, stall A (start,len), stall B (start,len), expected stream, DONE cycle
    vecs[0] = '{1'b1, 16'hA5C3, 0, 0, 0, 0, 16'hA5C3, 21};
    vecs[1] = '{1'b0, 16'hA5C3, 0, 0, 0, 0, 16'hC3A5, 21};
    vecs[2] = '{1'b1, 16'hA5C3, 8, 3, 14, 1, 16'hA5C3, 25};
    vecs[3] = '{1'b0, 16'h1234, 0, 0, 0, 0, 16'h2C48, 21};
    vecs[4] = '{1'b1, 16'hFFFF, 2, 1, 0, 0, 16'hFFFF, 22};
    vecs[5] = '{1'b0, 16'h8001, 1, 2, 0, 0, 16'h8001, 23};

    RST_N = 1'b0;
    reqValid = 1'b0; reqData = '0; reqMsb = 1'b0; serStall = 1'b0;
    reqValid1 = 1'b0; reqData1 = '0; reqMsb1 = 1'b0; serStall1 = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", 32'(reqReady), 32'd0);
    check("rst_valid", 32'(serValid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_enb", 32'(srEnb), 32'd0);
    check("rst_modo", 32'(srModo), 32'(MODO_SHIFT));
    check("rst_d", 32'(srD), 32'd0);
    check("rst_dir", 32'(srDir), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("ready_after_release", 32'(reqReady), 32'd1);

    for (int i = 0; i < 6; i++) runVec(vecs[i], i);

    // Reset in the middle of a word: outputs drop at once, no DONE follows.
    @(posedge CLK); #1;
    reqValid = 1'b1; reqData = 16'hA5C3; reqMsb = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK); #1;
      reqValid = 1'b0;
    end
    check("midrst_valid_before", 32'(serValid), 32'd1);
    RST_N = 1'b0;
    #1;
    check("midrst_valid", 32'(serValid), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_enb", 32'(srEnb), 32'd0);
    check("midrst_ready", 32'(reqReady), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("midrst_ready_release", 32'(reqReady), 32'd1);
    doneSeen = 0;
    repeat (30) begin
      @(negedge CLK);
      if (done) doneSeen++;
    end
    check("midrst_no_done", 32'(doneSeen), 32'd0);

    // Back-to-back words with REQ_VALID held high; data changes while busy.
    @(posedge CLK); #1;
    reqValid = 1'b1; reqData = 16'h3C5A; reqMsb = 1'b1;
    firstReady = -1; d1 = -1; d2 = -1; doneCnt = 0; w1 = '0; w2 = '0;
    for (int c = 1; c <= 70 && d2 < 0; c++) begin
      @(posedge CLK); #1;
      if (c == 5) reqData = 16'h9999;
      reqValid = (c <= 22);
      @(negedge CLK);
      if (reqReady && firstReady < 0) firstReady = c;
      if (serValid) begin
        if (doneCnt == 0) w1 = {w1[14:0], serBit};
        else w2 = {w2[14:0], serBit};
      end
      if (done) begin
        if (doneCnt == 0) d1 = c;
        else d2 = c;
        doneCnt++;
      end
    end
    reqValid = 1'b0;
    check("hs_first_ready", 32'(firstReady), 32'd22);
    check("hs_word1", 32'(w1), 32'h3C5A);
    check("hs_done1", 32'(d1), 32'd21);
    check("hs_word2", 32'(w2), 32'h9999);
    check("hs_done2", 32'(d2), 32'd43);

    // NIB=1 instance: MSB-first 9 and LSB-first C.
    for (int k = 0; k < 2; k++) begin
      int dc;
      @(posedge CLK); #1;
      reqValid1 = 1'b1;
      reqMsb1 = (k == 0);
      reqData1 = (k == 0) ? 4'h9 : 4'hC;
      b1 = '0; dc = -1;
      @(negedge CLK);
      check($sformatf("n1_%0d_ready", k), 32'(reqReady1), 32'd1);
      for (int c = 1; c <= 20 && dc < 0; c++) begin
        @(posedge CLK); #1;
        reqValid1 = 1'b0;
        @(negedge CLK);
        if (serValid1) b1 = {b1[2:0], serBit1};
        if (done1) dc = c;
      end
      @(negedge CLK);
      check($sformatf("n1_%0d_bits", k), 32'(b1), (k == 0) ? 32'h9 : 32'h3);
      check($sformatf("n1_%0d_done", k), 32'(dc), 32'd6);
      check($sformatf("n1_%0d_ready_after", k), 32'(reqReady1), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
